// File: rtl/audio_pkg.sv
// Shared types, default sizes and the sample conversion used by audio_sample_sink.
package audio_pkg;
    localparam int SAMPLE_W       = 8;
    localparam int OUT_W          = 16;
    localparam int VOL_MAX        = 7;
    localparam int VOL_W          = 3;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic {PRIME = 1'b0, RUN = 1'b1} sink_state_t;

    // Left-align the signed sample in the codec word, then attenuate by 2^-(VOL_MAX-volume).
    function automatic logic [OUT_W-1:0] convert_sample(
        input logic [SAMPLE_W-1:0] sample,
        input logic [VOL_W-1:0]    volume,
        input logic                mute
    );
        logic signed [OUT_W-1:0] aligned;
        logic signed [OUT_W-1:0] scaled;
        logic [VOL_W-1:0]        shift;
        aligned = {sample, {(OUT_W-SAMPLE_W){1'b0}}};
        shift   = VOL_W'(VOL_MAX) - volume;
        scaled  = aligned >>> shift;
        return mute ? '0 : scaled;
    endfunction
endpackage

// File: rtl/audio_sample_sink_fifo.sv
// Small synchronous sample FIFO with wrap-bit pointers; a write into a full FIFO is
// accepted when a read happens in the same cycle. Read data is the current head.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_wr;
    logic             do_rd;

    assign level   = wptr_q - rptr_q;
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign do_rd   = rd & ~empty & ~clear;
    assign do_wr   = wr & (~full | do_rd) & ~clear;
    assign rd_data = mem[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_wr) wptr_d = wptr_q + 1'b1;
            if (do_rd) rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/audio_sample_sink.sv
// Buffers strobed 8-bit samples, applies volume/mute at load time and feeds the codec
// over valid/ready, re-priming the FIFO to half full after every underrun.
module audio_sample_sink
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SAMPLE_W-1:0]           sample_in,
    input  logic                          sample_strobe,
    input  logic                          flush,
    input  logic                          vol_up,
    input  logic                          vol_down,
    input  logic                          mute,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [VOL_W-1:0]              volume,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   underrun_count
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0]    HALF    = LW'(FIFO_DEPTH / 2);
    localparam logic [VOL_W-1:0] VOL_TOP = VOL_W'(VOL_MAX);

    sink_state_t       state_q, state_d;
    logic              strobe_q;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [VOL_W-1:0]  volume_q, volume_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       underrun_q, underrun_d;

    logic              wr;
    logic              fifo_wr;
    logic              pop;
    logic              underrun;
    logic              fifo_full;
    logic              fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;
    logic [LW-1:0]     level;

    assign wr      = sample_strobe & ~strobe_q;
    assign fifo_wr = wr & ~flush;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .wr      (fifo_wr),
        .rd      (pop),
        .wr_data (sample_in),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= PRIME;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = PRIME;
        end else begin
            case (state_q)
                PRIME:   if (level >= HALF) state_d = RUN;
                RUN:     if (underrun)      state_d = PRIME;
                default: state_d = PRIME;
            endcase
        end
    end

    // FSM outputs: a load slot opens whenever the output register is empty or being taken.
    always_comb begin
        pop      = 1'b0;
        underrun = 1'b0;
        if (state_q == RUN && !flush && (!out_valid_q || out_ready)) begin
            if (fifo_empty) underrun = 1'b1;
            else            pop      = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        underrun_d  = underrun_q;
        if (flush) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (pop) begin
                out_data_d  = convert_sample(fifo_head, volume_q, mute);
                out_valid_d = 1'b1;
            end else if (underrun) begin
                out_valid_d = 1'b0;
            end
            if (wr && fifo_full && !pop) overflow_d = 1'b1;
        end
        if (underrun && underrun_q != 16'hFFFF) underrun_d = underrun_q + 1'b1;
    end

    always_comb begin
        volume_d = volume_q;
        if (vol_up && !vol_down && volume_q != VOL_TOP)
            volume_d = volume_q + 1'b1;
        else if (vol_down && !vol_up && volume_q != '0)
            volume_d = volume_q - 1'b1;
    end

    // Edge register resets high so a strobe already asserted at release is not a new sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q    <= 1'b1;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            volume_q    <= VOL_TOP;
            overflow_q  <= 1'b0;
            underrun_q  <= '0;
        end else begin
            strobe_q    <= sample_strobe;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            volume_q    <= volume_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
        end
    end

    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign volume         = volume_q;
    assign fifo_level     = level;
    assign overflow       = overflow_q;
    assign underrun_count = underrun_q;
endmodule

// File: tb/tb_audio_sample_sink.sv
// Bench for audio_sample_sink: a queue-based reference model runs in lockstep, plus
// a conversion table and directed sequences for priming, overflow, flush and hold.
module tb_audio_sample_sink;
    logic        clk = 1'b0;
    logic        reset, sample_strobe, flush, vol_up, vol_down, mute, out_ready;
    logic [7:0]  sample_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic [2:0]  volume;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] underrun_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    byte unsigned m_q[$];
    bit           m_prime, m_valid, m_ovf, m_prev;
    logic [15:0]  m_data, m_under;
    int           m_vol;
    logic [15:0]  got[$];

    typedef struct {
        logic [7:0]  s;
        int          vol;
        bit          mu;
        logic [15:0] exp;
    } conv_vec_t;
    conv_vec_t vecs[10];

    always #5 clk = ~clk;

    audio_sample_sink dut (
        .clk            (clk),
        .reset          (reset),
        .sample_in      (sample_in),
        .sample_strobe  (sample_strobe),
        .flush          (flush),
        .vol_up         (vol_up),
        .vol_down       (vol_down),
        .mute           (mute),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .volume         (volume),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .underrun_count (underrun_count)
    );

    function automatic logic [15:0] ref_conv(input byte unsigned s, input int vol, input bit mu);
        int v;
        if (mu) return 16'h0000;
        v = (s >= 128) ? int'(s) - 256 : int'(s);
        v = (v * 256) >>> (7 - vol);
        return v[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model one clock using the inputs currently applied.
    task automatic model_step();
        int level0;
        bit edge_s, popped;
        if (reset) begin
            m_q.delete();
            m_prime = 1; m_valid = 0; m_data = 0; m_ovf = 0; m_under = 0; m_vol = 7; m_prev = 1;
            return;
        end
        edge_s = sample_strobe && !m_prev;
        m_prev = sample_strobe;
        level0 = m_q.size();
        popped = 0;
        if (flush) begin
            m_q.delete();
            m_valid = 0; m_data = 0; m_ovf = 0; m_prime = 1;
        end else begin
            if (m_prime) begin
                if (level0 >= 4) m_prime = 0;
            end else if (!m_valid || out_ready) begin
                if (level0 > 0) begin
                    m_data  = ref_conv(m_q.pop_front(), m_vol, mute);
                    m_valid = 1;
                    popped  = 1;
                end else begin
                    m_valid = 0;
                    if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
                    m_prime = 1;
                end
            end
            if (edge_s) begin
                if (level0 < 8 || popped) m_q.push_back(sample_in);
                else                      m_ovf = 1;
            end
        end
        if (vol_up && !vol_down && m_vol < 7)      m_vol++;
        else if (vol_down && !vol_up && m_vol > 0) m_vol--;
    endtask

    task automatic step();
        if (!reset && out_valid && out_ready) got.push_back(out_data);
        model_step();
        @(posedge clk);
        #1;
        chk("out_valid",      32'(out_valid),      32'(m_valid));
        chk("out_data",       32'(out_data),       32'(m_data));
        chk("volume",         32'(volume),         32'(m_vol));
        chk("fifo_level",     32'(fifo_level),     32'(m_q.size()));
        chk("overflow",       32'(overflow),       32'(m_ovf));
        chk("underrun_count", 32'(underrun_count), 32'(m_under));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [7:0] s);
        sample_in = s; sample_strobe = 1'b1; step();
        sample_strobe = 1'b0; step();
    endtask

    task automatic pulse_flush();
        flush = 1'b1; step();
        flush = 1'b0; step();
    endtask

    task automatic set_vol(input int v);
        vol_up = 1'b1; idle(7); vol_up = 1'b0;
        vol_down = 1'b1; idle(7 - v); vol_down = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rdy_pct;
        vecs[0] = '{8'h10, 7, 1'b0, 16'h1000};
        vecs[1] = '{8'h80, 4, 1'b0, 16'hF000};
        vecs[2] = '{8'h7F, 7, 1'b0, 16'h7F00};
        vecs[3] = '{8'h7F, 0, 1'b0, 16'h00FE};
        vecs[4] = '{8'h80, 0, 1'b0, 16'hFF00};
        vecs[5] = '{8'hFF, 7, 1'b0, 16'hFF00};
        vecs[6] = '{8'hFF, 0, 1'b0, 16'hFFFE};
        vecs[7] = '{8'h55, 3, 1'b1, 16'h0000};
        vecs[8] = '{8'hC0, 5, 1'b0, 16'hF000};
        vecs[9] = '{8'h01, 6, 1'b0, 16'h0080};

        reset = 1'b1; sample_strobe = 1'b1; flush = 1'b0; vol_up = 1'b0; vol_down = 1'b0;
        mute = 1'b0; out_ready = 1'b1; sample_in = 8'h00;
        idle(2);
        reset = 1'b0;
        idle(2);
        chk("no_write_at_release", 32'(fifo_level), 32'd0);
        chk("reset_volume", 32'(volume), 32'd7);
        sample_strobe = 1'b0;
        idle(1);

        // Priming then four back-to-back words and an underrun.
        got.delete();
        for (int i = 1; i <= 4; i++) push(8'(i * 16));
        idle(8);
        chk("prime_word_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("prime_word", 32'(got[k]), 32'((k + 1) * 16'h1000));
        chk("underrun_once", 32'(underrun_count), 32'd1);
        chk("valid_after_underrun", 32'(out_valid), 32'd0);

        // Strobe held high: one write only.
        sample_in = 8'h55; sample_strobe = 1'b1; idle(10);
        sample_strobe = 1'b0; idle(1);
        chk("held_strobe_level", 32'(fifo_level), 32'd1);

        // Overflow with the codec stalled, then flush.
        pulse_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(8'h11 + 8'(i));
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(fifo_level), 32'd8);
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_ovf", 32'(overflow), 32'd0);
        chk("flush_level", 32'(fifo_level), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        push(8'h33); idle(4);
        chk("flush_to_prime", 32'(out_valid), 32'd0);
        pulse_flush();

        // Dropped sample never reaches the codec.
        out_ready = 1'b0; got.delete();
        for (int i = 0; i < 10; i++) push(8'h21 + 8'(i));
        out_ready = 1'b1;
        idle(20);
        chk("drain_count", 32'(got.size()), 32'd9);
        chk("drain_last", 32'(got[8]), 32'h2900);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Volume stepping and saturation.
        pulse_flush();
        vol_down = 1'b1; idle(3); vol_down = 1'b0; idle(1);
        chk("vol_down3", 32'(volume), 32'd4);
        got.delete();
        for (int i = 0; i < 4; i++) push(8'h80);
        idle(8);
        chk("vol4_word", 32'(got[0]), 32'hF000);
        vol_down = 1'b1; idle(6); vol_down = 1'b0;
        chk("vol_floor", 32'(volume), 32'd0);
        vol_up = 1'b1; vol_down = 1'b1; idle(1); vol_up = 1'b0; vol_down = 1'b0;
        chk("vol_both_at0", 32'(volume), 32'd0);
        vol_up = 1'b1; idle(3); vol_up = 1'b0;
        vol_up = 1'b1; vol_down = 1'b1; idle(1); vol_up = 1'b0; vol_down = 1'b0;
        chk("vol_both_at3", 32'(volume), 32'd3);
        vol_up = 1'b1; idle(9); vol_up = 1'b0;
        chk("vol_ceiling", 32'(volume), 32'd7);

        // Held word is immune to mute/volume changes; the next word is not.
        pulse_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h40);
        for (int c = 0; c < 20 && !out_valid; c++) step();
        chk("hold_valid", 32'(out_valid), 32'd1);
        mute = 1'b1; vol_down = 1'b1; idle(2); vol_down = 1'b0; idle(2);
        chk("hold_data", 32'(out_data), 32'h4000);
        out_ready = 1'b1; step(); out_ready = 1'b0; step();
        chk("next_muted", 32'(out_data), 32'h0000);
        chk("next_muted_valid", 32'(out_valid), 32'd1);
        mute = 1'b0; out_ready = 1'b1; step();
        chk("next_vol5", 32'(out_data), 32'h1000);
        idle(6);
        set_vol(7);

        // Conversion table.
        foreach (vecs[r]) begin
            pulse_flush();
            set_vol(vecs[r].vol);
            mute = vecs[r].mu; out_ready = 1'b1; got.delete();
            for (int i = 0; i < 4; i++) push(vecs[r].s);
            idle(8);
            chk($sformatf("conv_row%0d", r), 32'(got[0]), 32'(vecs[r].exp));
            mute = 1'b0;
        end
        set_vol(7);

        // Randomized traffic against the model.
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rdy_pct = (c / 500 % 3 == 0) ? 90 : ((c / 500 % 3 == 1) ? 15 : 50);
            sample_in = 8'($urandom);
            if ($urandom_range(0, 2) == 0) sample_strobe = ~sample_strobe;
            flush     = ($urandom_range(0, 199) == 0);
            vol_up    = !flush && ($urandom_range(0, 29) == 0);
            vol_down  = !flush && ($urandom_range(0, 29) == 0);
            mute      = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
